// File: rtl/neuroset_pkg.sv
// Shared types and constants for the neuroset host-side feeder.
//   feeder_state_t : feeder FSM states
//   RES_ERR_CLASS  : class reported with every error result
//   DEF_SIZE_1     : default pixel word width (matches the core)
//   DEF_ADDR_W     : default database address width
package neuroset_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        GO,
        WAIT_CLR,
        WAIT_DONE,
        RESP
    } feeder_state_t;

    localparam logic [3:0] RES_ERR_CLASS = 4'hF;
    localparam int         DEF_SIZE_1    = 11;
    localparam int         DEF_ADDR_W    = 13;

endpackage

// File: rtl/feeder_timeout.sv
// Wait-state watchdog for the database feeder: a loadable up-counter with
// clear and an expire flag.
//   clk, rst_n  : clock, synchronous active-low reset
//   i_clr       : force count to zero (highest priority)
//   i_load      : load i_load_val
//   i_load_val  : value for i_load
//   i_en        : count this cycle
//   o_expired   : the count reaches TIMEOUT_CYC at the coming edge
module feeder_timeout #(
    parameter  int TIMEOUT_CYC = 1048575,
    localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != CNT_W'(TIMEOUT_CYC))) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Flagging one count early makes a wait state last exactly TIMEOUT_CYC
    // cycles: the exit edge is the one where the count would hit TIMEOUT_CYC.
    assign o_expired = i_en && (r_count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/database_feeder.sv
// Host-side initiator for the neuroset inference core. Takes one picture as a
// valid/ready word stream, writes it into the core database port, pulses GO,
// waits for STOP and returns the 4-bit class (4'hF with res_err on error).
//   clk, rst_n                     : clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last  : picture word stream in
//   db_we/db_dp/db_addr            : core database write port
//   core_go/core_stop/core_result  : core run control and result
//   res_valid/res_ready            : result handshake
//   res_class/res_err              : result payload
//
// state     | meaning
// IDLE      | result consumed, word index cleared
// LOAD      | accepting and writing picture words
// DRAIN     | picture too long, dropping words until s_last
// GO        | guard cycle after last write, then one-cycle GO
// WAIT_CLR  | waiting for the previous run's STOP to drop
// WAIT_DONE | waiting for STOP, result latched when it rises
// RESP      | result presented until res_ready
module database_feeder
    import neuroset_pkg::*;
#(
    parameter int SIZE_1      = DEF_SIZE_1,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int IMG_WORDS   = 784,
    parameter int IMG_BASE    = 0,
    parameter int TIMEOUT_CYC = 1048575
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [SIZE_1-1:0] s_data,
    input  logic              s_last,
    output logic              db_we,
    output logic [SIZE_1-1:0] db_dp,
    output logic [ADDR_W-1:0] db_addr,
    output logic              core_go,
    input  logic              core_stop,
    input  logic [3:0]        core_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [3:0]        res_class,
    output logic              res_err
);

    localparam int IDX_W = $clog2(IMG_WORDS + 1);

    feeder_state_t     r_state;
    feeder_state_t     w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [1:0]        r_go_cnt;
    logic              r_db_we;
    logic [SIZE_1-1:0] r_db_dp;
    logic [ADDR_W-1:0] r_db_addr;
    logic [3:0]        r_res_class;
    logic              r_res_err;

    logic w_hs;
    logic w_last_idx;
    logic w_in_wait;
    logic w_tmr_clr;
    logic w_expired;
    logic w_set_err;
    logic w_set_ok;

    assign w_hs       = s_valid && s_ready;
    assign w_last_idx = (r_idx == IDX_W'(IMG_WORDS - 1));
    assign w_in_wait  = (r_state == WAIT_CLR) || (r_state == WAIT_DONE);
    // Restart the watchdog on every entry into a wait state, including the
    // WAIT_CLR -> WAIT_DONE hop.
    assign w_tmr_clr  = (w_state_nxt != r_state) &&
                        ((w_state_nxt == WAIT_CLR) || (w_state_nxt == WAIT_DONE));

    feeder_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_tmr_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_in_wait),
        .o_expired  (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        core_go     = 1'b0;
        res_valid   = 1'b0;
        w_set_err   = 1'b0;
        w_set_ok    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_state_nxt = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                if (w_hs) begin
                    if (w_last_idx) begin
                        w_state_nxt = s_last ? GO : DRAIN;
                    end else if (s_last) begin
                        w_state_nxt = RESP;
                        w_set_err   = 1'b1;
                    end
                end
            end
            DRAIN: begin
                s_ready = 1'b1;
                if (w_hs && s_last) begin
                    w_state_nxt = RESP;
                    w_set_err   = 1'b1;
                end
            end
            GO: begin
                // cycle 0: final write on the port, cycle 1: guard, cycle 2: GO
                if (r_go_cnt == 2'd2) begin
                    core_go     = 1'b1;
                    w_state_nxt = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (!core_stop) begin
                    w_state_nxt = WAIT_DONE;
                end else if (w_expired) begin
                    w_state_nxt = RESP;
                    w_set_err   = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (core_stop) begin
                    w_state_nxt = RESP;
                    w_set_ok    = 1'b1;
                end else if (w_expired) begin
                    w_state_nxt = RESP;
                    w_set_err   = 1'b1;
                end
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_go_cnt    <= '0;
            r_db_we     <= 1'b0;
            r_db_dp     <= '0;
            r_db_addr   <= '0;
            r_res_class <= '0;
            r_res_err   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_db_we  <= 1'b0;
            r_go_cnt <= (r_state == GO) ? r_go_cnt + 2'd1 : 2'd0;
            if ((r_state == LOAD) && w_hs) begin
                r_db_we   <= 1'b1;
                r_db_dp   <= s_data;
                r_db_addr <= ADDR_W'(IMG_BASE) + ADDR_W'(r_idx);
                r_idx     <= r_idx + IDX_W'(1);
            end else if (r_state == IDLE) begin
                r_idx <= '0;
            end
            if (w_set_err) begin
                r_res_class <= RES_ERR_CLASS;
                r_res_err   <= 1'b1;
            end else if (w_set_ok) begin
                r_res_class <= core_result;
                r_res_err   <= 1'b0;
            end
        end
    end

    assign db_we     = r_db_we;
    assign db_dp     = r_db_dp;
    assign db_addr   = r_db_addr;
    assign res_class = r_res_class;
    assign res_err   = r_res_err;

endmodule

// File: tb/tb_database_feeder.sv
module tb_database_feeder;

    localparam int SIZE_1    = 11;
    localparam int ADDR_W    = 13;
    localparam int IMG_WORDS = 784;
    localparam int IMG_BASE  = 0;
    localparam int TMO       = 1000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [SIZE_1-1:0] s_data;
    logic              s_last;
    logic              db_we;
    logic [SIZE_1-1:0] db_dp;
    logic [ADDR_W-1:0] db_addr;
    logic              core_go;
    logic              core_stop;
    logic [3:0]        core_result;
    logic              res_valid;
    logic              res_ready;
    logic [3:0]        res_class;
    logic              res_err;

    always #5 clk = ~clk;

    database_feeder #(
        .SIZE_1      (SIZE_1),
        .ADDR_W      (ADDR_W),
        .IMG_WORDS   (IMG_WORDS),
        .IMG_BASE    (IMG_BASE),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .db_we       (db_we),
        .db_dp       (db_dp),
        .db_addr     (db_addr),
        .core_go     (core_go),
        .core_stop   (core_stop),
        .core_result (core_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_class   (res_class),
        .res_err     (res_err)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [SIZE_1-1:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        exp_w;
    logic [3:0] exp_class;
    logic       exp_err;
    int         wr_seen;
    int         go_seen;
    int         go_cyc;
    int         rv_first_cyc;
    int         stop_cyc;
    logic       rv_prev = 1'b0;
    logic       we_h1   = 1'b0;
    logic       we_h2   = 1'b0;

    // Core model: STOP drops when GO is seen, rises core_delay cycles later
    // with the result. Mode 1 never raises STOP; mode 2 holds STOP at 1.
    int         core_mode  = 0;
    int         core_delay = 500;
    int         core_cnt   = 0;
    logic [3:0] core_res_val;

    always @(negedge clk) begin
        if (core_mode == 2) begin
            core_stop = 1'b1;
        end else if (core_go === 1'b1) begin
            core_stop   = 1'b0;
            core_result = 4'hC;
            core_cnt    = (core_mode == 1) ? 0 : core_delay;
        end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_stop   = 1'b1;
                core_result = core_res_val;
                stop_cyc    = cyc;
            end
        end
    end

    // Compare process: every write, every GO, every cycle a result is shown.
    always @(negedge clk) begin
        if (db_we === 1'b1) begin
            wr_seen++;
            check("db_addr_in_range", 32'(db_addr <= ADDR_W'(IMG_BASE + IMG_WORDS - 1)), 1);
            if (exp_q.size() == 0) begin
                fail_now("extra_write", $sformatf("db_we=1 at addr %0d, required no write", db_addr));
            end else begin
                exp_w = exp_q.pop_front();
                check("db_addr", db_addr, exp_w.addr);
                check("db_dp", db_dp, exp_w.data);
            end
        end
        if (core_go === 1'b1) begin
            go_seen++;
            go_cyc = cyc;
            check("go_guard_we_hist", {we_h2, we_h1}, 2'b10);
        end
        if (res_valid === 1'b1) begin
            if (!rv_prev) rv_first_cyc = cyc;
            check("res_class", res_class, exp_class);
            check("res_err", res_err, exp_err);
        end
        rv_prev = (res_valid === 1'b1);
        we_h2   = we_h1;
        we_h1   = (db_we === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [SIZE_1-1:0] pix(input int k, input int pat);
        if (pat == 0) return SIZE_1'(k % 1024);
        return SIZE_1'((k * 37 + 11) % 2048);
    endfunction

    task automatic begin_test(input logic err, input logic [3:0] cls);
        wr_seen   = 0;
        go_seen   = 0;
        exp_err   = err;
        exp_class = err ? 4'hF : cls;
    endtask

    task automatic send_word(input logic [SIZE_1-1:0] d, input logic last, input bit gaps);
        int t;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        t = 0;
        while (s_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (s_ready !== 1'b1) fail_now("s_ready_wait", "s_ready never rose within 100 cycles");
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Only the first IMG_WORDS words of a picture ever reach the database.
    task automatic send_picture(input int n_words, input int pat, input bit gaps);
        for (int k = 0; k < n_words; k++) begin
            if (k < IMG_WORDS) exp_q.push_back('{addr: ADDR_W'(IMG_BASE + k), data: pix(k, pat)});
            send_word(pix(k, pat), k == n_words - 1, gaps);
        end
    endtask

    task automatic take_result(input int hold);
        int t;
        t = 0;
        while (res_valid !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (res_valid !== 1'b1) begin
            fail_now("res_valid_wait", "res_valid never rose within 5000 cycles");
        end else begin
            repeat (hold) @(negedge clk);
            if (hold > 0) begin
                check("res_valid_held", res_valid, 1);
                check("s_ready_in_resp", s_ready, 0);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            check("res_valid_drop", res_valid, 0);
        end
    endtask

    task automatic end_test(input int n_wr, input int n_go);
        check("write_count", wr_seen, n_wr);
        check("go_count", go_seen, n_go);
        check("exp_q_empty", exp_q.size(), 0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rst_n       = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        s_last      = 1'b0;
        res_ready   = 1'b0;
        core_stop   = 1'b1;
        core_result = 4'h0;
        core_res_val = 4'h7;
        exp_class   = 4'h0;
        exp_err     = 1'b0;

        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_db_we", db_we, 0);
        check("rst_db_dp", db_dp, 0);
        check("rst_db_addr", db_addr, 0);
        check("rst_core_go", core_go, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_class", res_class, 0);
        check("rst_res_err", res_err, 0);
        rst_n = 1'b1;

        // 1: nominal picture, STOP after 500 cycles with class 7
        core_res_val = 4'h7;
        begin_test(1'b0, 4'h7);
        send_picture(IMG_WORDS, 0, 1'b0);
        take_result(0);
        end_test(784, 1);
        check("t1_stop_to_valid", rv_first_cyc, stop_cyc + 1);

        // 2: bursty input, result held 20 cycles before it is taken
        core_res_val = 4'h3;
        begin_test(1'b0, 4'h3);
        send_picture(IMG_WORDS, 1, 1'b1);
        take_result(20);
        end_test(784, 1);

        // 3: short picture
        begin_test(1'b1, 4'h0);
        send_picture(100, 0, 1'b0);
        take_result(3);
        end_test(100, 0);

        // 4: long picture, tail dropped
        begin_test(1'b1, 4'h0);
        send_picture(800, 1, 1'b0);
        take_result(2);
        end_test(784, 0);

        // 5a: STOP never rises, timeout out of WAIT_DONE
        core_mode = 1;
        begin_test(1'b1, 4'h0);
        send_picture(IMG_WORDS, 0, 1'b0);
        take_result(0);
        end_test(784, 1);
        check("t5a_timeout_cyc", rv_first_cyc, go_cyc + 2 + TMO);

        // 5b: STOP stuck high, timeout out of WAIT_CLR
        core_mode = 2;
        begin_test(1'b1, 4'h0);
        send_picture(IMG_WORDS, 1, 1'b0);
        take_result(0);
        end_test(784, 1);
        check("t5b_timeout_cyc", rv_first_cyc, go_cyc + 1 + TMO);
        core_mode = 0;

        // 6: reset during LOAD at word 300, then a fresh picture
        begin_test(1'b0, 4'h0);
        for (int k = 0; k < 300; k++) begin
            exp_q.push_back('{addr: ADDR_W'(IMG_BASE + k), data: pix(k, 0)});
            send_word(pix(k, 0), 1'b0, 1'b0);
        end
        #1;
        s_valid = 1'b1;
        s_data  = pix(300, 0);
        rst_n   = 1'b0;
        @(negedge clk);
        check("t6_rst_db_we", db_we, 0);
        check("t6_rst_s_ready", s_ready, 0);
        check("t6_rst_core_go", core_go, 0);
        check("t6_rst_res_valid", res_valid, 0);
        rst_n   = 1'b1;
        s_valid = 1'b0;
        end_test(300, 0);

        core_res_val = 4'h9;
        begin_test(1'b0, 4'h9);
        send_picture(IMG_WORDS, 0, 1'b0);
        take_result(1);
        end_test(784, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish by 5 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
